// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and default sizes for the convolution memory server
package conv_pkg;

    localparam int KERNEL_SIZE_DEF     = 3;
    localparam int DATA_WIDTH_DEF      = 8;
    localparam int SRAM_ADDR_WIDTH_DEF = 4;
    localparam int SRAM_DEPTH_DEF      = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FILL_KERNEL = 3'd1,
        ST_FILL_WIN1   = 3'd2,
        ST_FILL_WIN2   = 3'd3,
        ST_SERVE       = 3'd4
    } conv_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_regfile.sv
// rtl/conv_regfile.sv - register file with synchronous write and zero-latency read
//
// Ports:
//   clk_i    write clock
//   we_i     write enable
//   waddr_i  write address (writes outside DEPTH are dropped)
//   wdata_i  write data
//   raddr_i  read address (reads outside DEPTH return 0)
//   rdata_o  read data, combinational; a same-cycle write is not forwarded
module conv_regfile #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Array rounded up to a power of two so the index is exactly IDX_W bits;
    // entries at or beyond DEPTH are never written or read.
    logic [DATA_W-1:0] mem_q [0:(1<<IDX_W)-1];

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = (32'(waddr_i) < DEPTH);
    assign rd_in_range = (32'(raddr_i) < DEPTH);

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i && wr_in_range) begin
            mem_q[IDX_W'(waddr_i)] <= wdata_i;
        end
    end

    assign rdata_o = rd_in_range ? mem_q[IDX_W'(raddr_i)] : '0;

endmodule

// File: rtl/conv_mem_server.sv
// rtl/conv_mem_server.sv - fills kernel and two window buffers, then serves reads to a convolver
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_load                          start a fill sequence (IDLE only)
//   i_wr_valid/o_wr_ready/i_wr_data write stream: kernel words, then window1, then window2
//   i_kernel_addr/o_kernel_data     kernel read port (zero latency)
//   i_window1_addr/o_window1_data   window1 read port (zero latency)
//   i_window2_addr/o_window2_data   window2 read port (zero latency)
//   o_conv_start                    one-cycle pulse on entry to SERVE
//   i_conv_done/i_conv_result       convolver completion and result
//   o_result/o_result_valid         latched result and its freshness flag
//   o_loaded                        high while buffers are served
module conv_mem_server
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE     = KERNEL_SIZE_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEF,
    parameter int SRAM_DEPTH      = SRAM_DEPTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_load,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [DATA_WIDTH-1:0]      i_wr_data,
    input  logic [5:0]                 i_kernel_addr,
    output logic [DATA_WIDTH-1:0]      o_kernel_data,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_window1_addr,
    output logic [DATA_WIDTH-1:0]      o_window1_data,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_window2_addr,
    output logic [DATA_WIDTH-1:0]      o_window2_data,
    output logic                       o_conv_start,
    input  logic                       i_conv_done,
    input  logic [DATA_WIDTH-1:0]      i_conv_result,
    output logic [DATA_WIDTH-1:0]      o_result,
    output logic                       o_result_valid,
    output logic                       o_loaded
);

    localparam int KK      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CNT_MAX = max_int(KK, SRAM_DEPTH);
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    conv_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic                  start_q, start_d;

    logic wr_fire;
    logic kernel_last;
    logic window_last;

    assign o_wr_ready = (state_q == ST_FILL_KERNEL) ||
                        (state_q == ST_FILL_WIN1)   ||
                        (state_q == ST_FILL_WIN2);
    assign wr_fire     = i_wr_valid && o_wr_ready;
    assign kernel_last = (32'(cnt_q) == KK - 1);
    assign window_last = (32'(cnt_q) == SRAM_DEPTH - 1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    state_d        = ST_FILL_KERNEL;
                    cnt_d          = '0;
                    result_valid_d = 1'b0;
                end
            end
            ST_FILL_KERNEL: begin
                if (wr_fire) begin
                    if (kernel_last) begin
                        state_d = ST_FILL_WIN1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FILL_WIN1: begin
                if (wr_fire) begin
                    if (window_last) begin
                        state_d = ST_FILL_WIN2;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FILL_WIN2: begin
                if (wr_fire) begin
                    if (window_last) begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SERVE: begin
                // i_load is ignored here, so done wins when both are high.
                if (i_conv_done) begin
                    state_d        = ST_IDLE;
                    result_d       = i_conv_result;
                    result_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Registered so the pulse covers exactly the first SERVE cycle.
        start_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            start_q        <= start_d;
        end
    end

    assign o_conv_start   = start_q;
    assign o_loaded       = (state_q == ST_SERVE);
    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;

    conv_regfile #(.DEPTH(KK), .DATA_W(DATA_WIDTH), .ADDR_W(6)) u_kernel (
        .clk_i   (i_clk),
        .we_i    (wr_fire && (state_q == ST_FILL_KERNEL)),
        .waddr_i (6'(cnt_q)),
        .wdata_i (i_wr_data),
        .raddr_i (i_kernel_addr),
        .rdata_o (o_kernel_data)
    );

    conv_regfile #(.DEPTH(SRAM_DEPTH), .DATA_W(DATA_WIDTH), .ADDR_W(SRAM_ADDR_WIDTH)) u_window1 (
        .clk_i   (i_clk),
        .we_i    (wr_fire && (state_q == ST_FILL_WIN1)),
        .waddr_i (SRAM_ADDR_WIDTH'(cnt_q)),
        .wdata_i (i_wr_data),
        .raddr_i (i_window1_addr),
        .rdata_o (o_window1_data)
    );

    conv_regfile #(.DEPTH(SRAM_DEPTH), .DATA_W(DATA_WIDTH), .ADDR_W(SRAM_ADDR_WIDTH)) u_window2 (
        .clk_i   (i_clk),
        .we_i    (wr_fire && (state_q == ST_FILL_WIN2)),
        .waddr_i (SRAM_ADDR_WIDTH'(cnt_q)),
        .wdata_i (i_wr_data),
        .raddr_i (i_window2_addr),
        .rdata_o (o_window2_data)
    );

endmodule

// File: tb/tb_conv_mem_server.sv
// tb/tb_conv_mem_server.sv - scoreboard testbench for conv_mem_server
module tb_conv_mem_server;

    localparam int SEL_KDATA = 0, SEL_W1 = 1, SEL_W2 = 2, SEL_RES = 3;
    localparam int SEL_VALID = 4, SEL_LOADED = 5, SEL_START = 6, SEL_READY = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_load = 1'b0;
    logic       i_wr_valid = 1'b0;
    logic [7:0] i_wr_data = '0;
    logic [5:0] k_addr = '0;
    logic [3:0] w1_addr = '0;
    logic [3:0] w2_addr = '0;
    logic       conv_done = 1'b0;
    logic [7:0] conv_result = '0;

    logic       o_wr_ready;
    logic [7:0] o_kernel_data;
    logic [7:0] o_window1_data;
    logic [7:0] o_window2_data;
    logic       o_conv_start;
    logic [7:0] o_result;
    logic       o_result_valid;
    logic       o_loaded;

    conv_mem_server dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_load         (i_load),
        .i_wr_valid     (i_wr_valid),
        .o_wr_ready     (o_wr_ready),
        .i_wr_data      (i_wr_data),
        .i_kernel_addr  (k_addr),
        .o_kernel_data  (o_kernel_data),
        .i_window1_addr (w1_addr),
        .o_window1_data (o_window1_data),
        .i_window2_addr (w2_addr),
        .o_window2_data (o_window2_data),
        .o_conv_start   (o_conv_start),
        .i_conv_done    (conv_done),
        .i_conv_result  (conv_result),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_loaded       (o_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    int         start_q[$];
    logic [7:0] res_q[$];

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    int   acc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            SEL_KDATA:  return 32'(o_kernel_data);
            SEL_W1:     return 32'(o_window1_data);
            SEL_W2:     return 32'(o_window2_data);
            SEL_RES:    return 32'(o_result);
            SEL_VALID:  return 32'(o_result_valid);
            SEL_LOADED: return 32'(o_loaded);
            SEL_START:  return 32'(o_conv_start);
            default:    return 32'(o_wr_ready);
        endcase
    endfunction

    function automatic logic [7:0] word(input int k);
        if (k < 9)       return 8'(k + 1);
        else if (k < 25) return 8'(8'h10 + k - 9);
        else             return 8'(8'h20 + k - 25);
    endfunction

    // Monitor: pops expectations whenever the DUT presents something to check.
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                check(c.name, sample(c.sel), c.exp);
            end
            if (o_conv_start) begin
                check("start_expected", 32'(start_q.size() > 0), 1);
                if (start_q.size() > 0) begin
                    check("start_latency", 32'(cyc - first_cyc), 32'(start_q.pop_front()));
                    check("ready_low_in_serve", 32'(o_wr_ready), 0);
                    check("loaded_at_start", 32'(o_loaded), 1);
                end
            end
            if (o_result_valid && !prev_valid) begin
                check("result_expected", 32'(res_q.size() > 0), 1);
                if (res_q.size() > 0) check("result_value", 32'(o_result), 32'(res_q.pop_front()));
            end
            prev_valid = o_result_valid;
            if (!o_wr_ready) acc = 0;
            else if (i_wr_valid) begin
                if (acc == 0) first_cyc = cyc;
                acc++;
            end
        end
    end

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic drain();
        int n = 0;
        while (chk_q.size() > 0 && n < 5) begin
            @(posedge clk);
            n++;
        end
        if (chk_q.size() > 0) begin
            check("drain_timeout", 32'(chk_q.size()), 0);
            chk_q.delete();
        end
        #1;
    endtask

    task automatic rd(input string name, input int sel, input int addr, input logic [31:0] exp);
        if (sel == SEL_KDATA)   k_addr  = 6'(addr);
        else if (sel == SEL_W1) w1_addr = 4'(addr);
        else                    w2_addr = 4'(addr);
        push(name, sel, exp);
        drain();
    endtask

    task automatic fill(input int gap, input int nwords);
        i_load = 1'b1;
        @(posedge clk); #1;
        i_load = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = word(k);
            @(posedge clk); #1;
            if (gap != 0) begin
                i_wr_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        i_wr_valid = 1'b0;
    endtask

    task automatic wait_loaded();
        int n = 0;
        while (!o_loaded && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_loaded", 32'(o_loaded), 1);
    endtask

    task automatic reset_outputs_zero(input string tag);
        push({tag, "_result"}, SEL_RES, 0);
        push({tag, "_valid"}, SEL_VALID, 0);
        push({tag, "_loaded"}, SEL_LOADED, 0);
        push({tag, "_start"}, SEL_START, 0);
        push({tag, "_ready"}, SEL_READY, 0);
        drain();
    endtask

    initial begin
        // Reset state
        reset_outputs_zero("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back fill
        start_q.push_back(41);
        fill(0, 41);
        wait_loaded();
        rd("k4", SEL_KDATA, 4, 8'h05);
        rd("k0", SEL_KDATA, 0, 8'h01);
        rd("k8", SEL_KDATA, 8, 8'h09);
        rd("w1_15", SEL_W1, 15, 8'h1F);
        rd("w1_0", SEL_W1, 0, 8'h10);
        rd("w2_0", SEL_W2, 0, 8'h20);
        rd("w2_15", SEL_W2, 15, 8'h2F);
        rd("k9_oob", SEL_KDATA, 9, 8'h00);
        rd("k63_oob", SEL_KDATA, 63, 8'h00);

        // Convolver done in SERVE
        res_q.push_back(8'hA5);
        conv_done = 1'b1;
        conv_result = 8'hA5;
        @(posedge clk); #1;
        conv_done = 1'b0;
        conv_result = 8'h00;
        push("done_result", SEL_RES, 8'hA5);
        push("done_valid", SEL_VALID, 1);
        push("done_loaded", SEL_LOADED, 0);
        push("done_idle_ready", SEL_READY, 0);
        drain();

        // Done outside SERVE is ignored
        conv_done = 1'b1;
        conv_result = 8'h33;
        @(posedge clk); #1;
        conv_done = 1'b0;
        push("idle_done_result", SEL_RES, 8'hA5);
        push("idle_done_valid", SEL_VALID, 1);
        drain();
        rd("idle_k4", SEL_KDATA, 4, 8'h05);
        rd("idle_w2_0", SEL_W2, 0, 8'h20);

        // Fill with valid toggling every other cycle
        start_q.push_back(81);
        fill(1, 41);
        wait_loaded();
        push("load_clears_valid", SEL_VALID, 0);
        drain();
        rd("t_k4", SEL_KDATA, 4, 8'h05);
        rd("t_k0", SEL_KDATA, 0, 8'h01);
        rd("t_w1_15", SEL_W1, 15, 8'h1F);
        rd("t_w1_7", SEL_W1, 7, 8'h17);
        rd("t_w2_0", SEL_W2, 0, 8'h20);
        rd("t_w2_9", SEL_W2, 9, 8'h29);

        // Load together with done in SERVE: done wins
        res_q.push_back(8'h5A);
        i_load = 1'b1;
        conv_done = 1'b1;
        conv_result = 8'h5A;
        @(posedge clk); #1;
        i_load = 1'b0;
        conv_done = 1'b0;
        push("both_loaded", SEL_LOADED, 0);
        push("both_ready", SEL_READY, 0);
        push("both_valid", SEL_VALID, 1);
        push("both_result", SEL_RES, 8'h5A);
        drain();
        push("both_still_idle", SEL_READY, 0);
        drain();

        // Reset in the middle of a fill
        fill(0, 20);
        rst_n = 1'b0;
        reset_outputs_zero("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_load = 1'b1;
        @(posedge clk); #1;
        i_load = 1'b0;
        i_wr_valid = 1'b1;
        i_wr_data = 8'h77;
        @(posedge clk); #1;
        i_wr_valid = 1'b0;
        rd("restart_k0", SEL_KDATA, 0, 8'h77);
        rd("restart_k1_kept", SEL_KDATA, 1, 8'h02);
        push("restart_ready", SEL_READY, 1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("start_q_empty", 32'(start_q.size()), 0);
        check("res_q_empty", 32'(res_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_mem_server.md
CONV_MEM_SERVER -- requirements
Module: conv_mem_server

Interface
REQ-001 The block SHALL take parameter KERNEL_SIZE, default 3, which sets the kernel edge length; the kernel holds KERNEL_SIZE*KERNEL_SIZE words.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8, which sets the width of every data word.
REQ-003 The block SHALL take parameter SRAM_ADDR_WIDTH, default 4, which sets the width of the window address.
REQ-004 The block SHALL take parameter SRAM_DEPTH, default 16, which sets the number of words in each window buffer.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, on these ports:
- i_clk  in  1  sole clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL provide these load-control and write-stream ports:
- i_load  in  1  request to start a fill sequence.
- i_wr_valid  in  1  write word valid.
- o_wr_ready  out  1  block accepts a write word.
- i_wr_data  in  DATA_WIDTH  write word.
REQ-007 The block SHALL provide these read-service ports, used by the convolver:
- i_kernel_addr  in  6  kernel read address.
- o_kernel_data  out  DATA_WIDTH  kernel read data.
- i_window1_addr  in  SRAM_ADDR_WIDTH  window1 read address.
- o_window1_data  out  DATA_WIDTH  window1 read data.
- i_window2_addr  in  SRAM_ADDR_WIDTH  window2 read address.
- o_window2_data  out  DATA_WIDTH  window2 read data.
REQ-008 The block SHALL provide these convolver-handshake and status ports:
- o_conv_start  out  1  one-cycle start pulse to the convolver.
- i_conv_done  in  1  convolver finished.
- i_conv_result  in  DATA_WIDTH  convolver result.
- o_result  out  DATA_WIDTH  latched result.
- o_result_valid  out  1  o_result holds a fresh value.
- o_loaded  out  1  all buffers are filled and being served.

Function
REQ-009 The block SHALL implement the states IDLE, FILL_KERNEL, FILL_WIN1, FILL_WIN2 and SERVE.
REQ-010 In IDLE, i_load=1 SHALL cause FILL_KERNEL on the next edge, clear the fill counter and clear o_result_valid.
REQ-011 A write SHALL occur only on a cycle with i_wr_valid=1 and o_wr_ready=1; the word is stored at the fill-counter address and the counter increments by 1.
REQ-012 o_wr_ready SHALL be 1 only in the FILL_KERNEL, FILL_WIN1 and FILL_WIN2 states, and combinationally equal to that state decode.
REQ-013 FILL_KERNEL SHALL end on the write that fills index KERNEL_SIZE*KERNEL_SIZE-1; the next state is FILL_WIN1 and the counter returns to 0.
REQ-014 FILL_WIN1 SHALL end on the write that fills index SRAM_DEPTH-1; the next state is FILL_WIN2 and the counter returns to 0.
REQ-015 FILL_WIN2 SHALL end on the write that fills index SRAM_DEPTH-1; the next state is SERVE.
REQ-016 o_conv_start SHALL pulse high for exactly the first cycle in SERVE.
REQ-017 o_loaded SHALL be 1 only while the block is in SERVE.
REQ-018 Cycles with i_wr_valid=0 during a fill SHALL stall the fill with no timeout.
REQ-019 Read data SHALL be combinational: o_*_data reflects the stored word at i_*_addr in the same cycle (zero latency).
REQ-020 i_kernel_addr >= KERNEL_SIZE*KERNEL_SIZE SHALL return 0.
REQ-021 A window address >= SRAM_DEPTH SHALL return 0; this only applies when SRAM_DEPTH < 2^SRAM_ADDR_WIDTH.
REQ-022 A read of the address being written in the same cycle SHALL return the old value; there is no write-through.
REQ-023 In SERVE, i_conv_done=1 SHALL latch i_conv_result into o_result, set o_result_valid and return the block to IDLE on the next edge.
REQ-024 Buffer contents SHALL be retained across IDLE, so reads in IDLE return the last filled data.
REQ-025 i_load outside IDLE SHALL be ignored.
REQ-026 i_conv_done outside SERVE SHALL be ignored.
REQ-027 i_load and i_conv_done asserted together in SERVE SHALL act on i_conv_done only.
REQ-028 In IDLE, o_result_valid SHALL stay set until the next accepted i_load.

Reset
REQ-029 While i_rst_n=0, asynchronously, the state SHALL be IDLE and the fill counter 0.
REQ-030 While i_rst_n=0, asynchronously, o_conv_start, o_loaded and o_result_valid SHALL be 0 and o_result SHALL be 0.
REQ-031 Buffer storage SHALL NOT be reset; its contents are undefined until first filled.
REQ-032 A reset in the middle of a fill SHALL abandon the sequence, and the next i_load SHALL restart from kernel index 0.

Structure
REQ-033 The state encoding and the default KERNEL_SIZE, DATA_WIDTH, SRAM_ADDR_WIDTH and SRAM_DEPTH values SHALL live in the shared package conv_pkg.
REQ-034 A sub-module conv_regfile (parameterised depth/width, synchronous write, asynchronous read, out-of-range read returns 0) SHALL be instanced three times: kernel, window1 and window2.
REQ-035 The FSM, fill counter and result latch SHALL reside in conv_mem_server.

Verification
REQ-036 Reset then i_load, stream values 1..9, then 16 words 0x10..0x1F, then 16 words 0x20..0x2F with i_wr_valid held high -> o_conv_start pulses once, 41 cycles after the first accepted word; o_kernel_data at address 4 = 5; o_window1_data at address 15 = 0x1F; o_window2_data at address 0 = 0x20.
REQ-037 The same fill with i_wr_valid toggled every other cycle -> identical buffer contents; o_wr_ready drops only when SERVE is reached.
REQ-038 In SERVE, drive i_conv_done=1 with i_conv_result=0xA5 -> o_result=0xA5 and o_result_valid=1 on the next cycle; state is IDLE; o_loaded=0.
REQ-039 Assert i_rst_n=0 after 20 accepted words -> all outputs are 0 immediately; a new i_load followed by a word 0x77 stores it at kernel index 0.
REQ-040 Read i_kernel_addr=9 and i_kernel_addr=63 in SERVE -> o_kernel_data=0.
REQ-041 Assert i_load in SERVE together with i_conv_done=1 -> state goes to IDLE (not FILL_KERNEL); o_result_valid=1.
